// File: rtl/nco_quad.sv
// Quadrature NCO: phase accumulator with tuning word, offset and sync, driving a
// quarter-wave sine table with symmetry folding through a 3-stage output pipeline.
module nco_quad #(
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned I_WIDTH   = 8,
  parameter int unsigned O_WIDTH   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [ACC_WIDTH-1:0]       i_ftw,
  input  logic                       i_ftw_load,
  input  logic [I_WIDTH-1:0]         i_phase_offset,
  input  logic                       i_sync,
  output logic signed [O_WIDTH-1:0]  o_sin,
  output logic signed [O_WIDTH-1:0]  o_cos,
  output logic                       o_valid,
  output logic                       o_wrap
);

  localparam int unsigned IDX_W = I_WIDTH - 2;
  localparam int unsigned MAG_W = O_WIDTH - 1;
  localparam int unsigned Q     = 1 << IDX_W;
  localparam int unsigned A     = (1 << MAG_W) - 1;
  localparam longint      FX_ONE = 64'sd1 << 30;
  localparam longint      PI_FX  = 64'sd3373259426;

  // round(A*sin(pi*k/(2Q))) via a fixed-point Taylor series, evaluated at elaboration
  function automatic logic [MAG_W-1:0] quarter_sine(input int unsigned k);
    longint x;
    longint term;
    longint s;
    x    = (longint'(k) * PI_FX) / longint'(2 * Q);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -((((term * x) / FX_ONE) * x) / FX_ONE) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return MAG_W'((s * longint'(A) + FX_ONE / 2) / FX_ONE);
  endfunction

  logic [MAG_W-1:0] qtab [Q];

  for (genvar k = 0; k < Q; k++) begin : g_tab
    localparam logic [MAG_W-1:0] QV = quarter_sine(k);
    assign qtab[k] = QV;
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] ftw_reg;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [I_WIDTH-1:0]   ph;
  logic                 v1;

  assign acc_sum = {1'b0, acc} + {1'b0, ftw_reg};

  // Accumulator and stage 1; the sample always takes the pre-update accumulator
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc     <= '0;
      ftw_reg <= '0;
      o_wrap  <= 1'b0;
      ph      <= '0;
      v1      <= 1'b0;
    end else begin
      if (i_ftw_load) ftw_reg <= i_ftw;
      if (i_sync)     acc <= '0;
      else if (i_en)  acc <= acc_sum[ACC_WIDTH-1:0];
      o_wrap <= i_en && !i_sync && acc_sum[ACC_WIDTH];
      ph     <= acc[ACC_WIDTH-1 -: I_WIDTH] + i_phase_offset;
      v1     <= i_en;
    end
  end

  logic [I_WIDTH-1:0] ph_cos;
  logic [IDX_W-1:0]   sin_idx;
  logic [IDX_W-1:0]   cos_idx;
  logic [MAG_W-1:0]   sin_mag;
  logic [MAG_W-1:0]   cos_mag;

  assign ph_cos  = ph + I_WIDTH'(Q);
  assign sin_idx = ph[IDX_W-1:0];
  assign cos_idx = ph_cos[IDX_W-1:0];

  // Odd quadrants read the table mirrored; idx 0 there is the peak, not stored
  always_comb begin
    sin_mag = qtab[sin_idx];
    cos_mag = qtab[cos_idx];
    if (ph[IDX_W]) begin
      sin_mag = (sin_idx == '0) ? MAG_W'(A) : qtab[IDX_W'(-sin_idx)];
    end
    if (ph_cos[IDX_W]) begin
      cos_mag = (cos_idx == '0) ? MAG_W'(A) : qtab[IDX_W'(-cos_idx)];
    end
  end

  logic [MAG_W-1:0] sin_mag_r;
  logic [MAG_W-1:0] cos_mag_r;
  logic             sin_neg;
  logic             cos_neg;
  logic             v2;

  // Stage 2 table read and sign flags, stage 3 sign application
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sin_mag_r <= '0;
      cos_mag_r <= '0;
      sin_neg   <= 1'b0;
      cos_neg   <= 1'b0;
      v2        <= 1'b0;
      o_sin     <= '0;
      o_cos     <= '0;
      o_valid   <= 1'b0;
    end else begin
      sin_mag_r <= sin_mag;
      cos_mag_r <= cos_mag;
      sin_neg   <= ph[I_WIDTH-1];
      cos_neg   <= ph_cos[I_WIDTH-1];
      v2        <= v1;
      o_valid   <= v2;
      if (v2) begin
        o_sin <= sin_neg ? -{1'b0, sin_mag_r} : {1'b0, sin_mag_r};
        o_cos <= cos_neg ? -{1'b0, cos_mag_r} : {1'b0, cos_mag_r};
      end
    end
  end

endmodule

// File: doc/nco_quad.md
Name: nco_quad

Overview:
- Parametrised numerically controlled oscillator; successor to the fixed-width sine LUT.
- Adds a programmable phase accumulator with frequency tuning word, a phase offset and phase sync.
- Uses an internal quarter-wave table with symmetry folding, and a pipelined quadrature output with valid and wrap flags.
- Feeds the sigma-delta modulator stimulus path and the demodulator's I/Q reference.

Parameters:
- ACC_WIDTH, 24, phase accumulator width (>= I_WIDTH).
- I_WIDTH, 8, table phase resolution in bits (>= 4); top I_WIDTH accumulator bits address the table.
- O_WIDTH, 8, signed two's-complement output width (>= 4).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  advance accumulator and launch one sample this cycle.
- i_ftw  in  ACC_WIDTH  frequency tuning word (unsigned).
- i_ftw_load  in  1  capture i_ftw into the internal FTW register.
- i_phase_offset  in  I_WIDTH  phase offset added after truncation (unsigned, modulo 2^I_WIDTH).
- i_sync  in  1  zero the accumulator.
- o_sin  out  O_WIDTH  signed sine sample.
- o_cos  out  O_WIDTH  signed cosine sample.
- o_valid  out  1  o_sin/o_cos hold a new sample this cycle.
- o_wrap  out  1  one-cycle pulse: accumulator overflowed on the previous i_en cycle.

Behaviour:
- Reset: acc, ftw_reg, all pipeline registers, o_sin, o_cos, o_valid and o_wrap are 0 on the cycle after i_rst is sampled high. Reset mid-stream discards in-flight samples; no o_valid until three cycles after the first i_en following reset release.
- FTW register:
  - ftw_reg <= i_ftw when i_ftw_load.
  - A load in the same cycle as i_en: the accumulation that cycle uses the old ftw_reg.
- Accumulator:
  - If i_sync: acc <= 0. i_sync has priority over i_en.
  - Else if i_en: acc <= acc + ftw_reg, modulo 2^ACC_WIDTH.
  - o_wrap <= carry-out of that addition when i_en && !i_sync; otherwise o_wrap <= 0.
- Stage 1 (cycle of i_en):
  - ph <= acc[ACC_WIDTH-1 -: I_WIDTH] + i_phase_offset, mod 2^I_WIDTH, using the pre-increment acc.
  - v1 <= i_en.
  - A sync with i_en: the sample uses the pre-sync acc.
- Stage 2:
  - Sine decode: quadrant = ph[I_WIDTH-1:I_WIDTH-2], idx = low I_WIDTH-2 bits.
  - Cosine decode: the same, using ph + 2^(I_WIDTH-2).
  - Table read and sign flags registered; v2 <= v1.
- Stage 3: apply sign, register o_sin, o_cos; o_valid <= v2.
- Latency: exactly 3 cycles from i_en to o_valid. The pipeline free-runs and is not stalled by i_en; valid bits track samples.
- Table definition:
  - Q = 2^(I_WIDTH-2), A = 2^(O_WIDTH-1) - 1.
  - q[k] = round(A·sin(π·k/(2Q))) for k = 0..Q-1, round half away from zero.
  - Generated at elaboration (function or initial block), Q words of O_WIDTH-1 bits.
- Folding (value for phase p = quadrant:idx):
  - Q0: q[idx].
  - Q1: A if idx = 0, else q[Q-idx].
  - Q2: -q[idx].
  - Q3: -A if idx = 0, else -q[Q-idx].
- Output properties:
  - The result equals round(A·sin(2πp/2^I_WIDTH)) exactly.
  - Output range is [-A, +A]; the code -2^(O_WIDTH-1) never appears.
  - Cosine: cos(p) = sin(p + Q).
- Held outputs: o_sin/o_cos hold their last value while o_valid is low.

Test Plan (ACC_WIDTH=8, I_WIDTH=8, O_WIDTH=8 unless stated):
- Reset: i_rst high 3 cycles with i_en high -> o_sin = o_cos = 0, o_valid = 0, o_wrap = 0 throughout and 2 cycles after release.
- Ramp: load ftw = 1, hold i_en -> o_valid first high 3 cycles after first i_en.
  - Sample n=0: sin 0, cos 127. n=1: sin 3. n=2: sin 6. n=64: sin 127, cos 0. n=128: sin 0, cos -127. n=192: sin -127 (0x81).
  - o_wrap pulses once per 256 samples.
- Quarter step: ftw = 64 -> sin 0, 127, 0, -127 repeating; cos 127, 0, -127, 0; o_wrap every 4th i_en cycle.
- Offset: ftw = 0, i_phase_offset = 64 -> sin = 127, cos = 0 on every valid sample. Change the offset to 128 -> sin = 0, cos = -127 after 3 cycles.
- Gating and collisions:
  - i_en toggled 1010…: o_valid = i_en delayed 3; acc advances only on enabled cycles.
  - i_ftw_load with i_en: the old step is applied once, then the new one.
  - i_sync with i_en: the current sample uses the old phase; the next sample is phase 0 + offset.
- Wide config: ACC_WIDTH=24, I_WIDTH=10, O_WIDTH=12, ftw = 2^22 -> samples every 256 table steps: sin 0, 2047, 0, -2047; mid-stream i_rst clears outputs next cycle.
